out_monitor: RTL and testbench

OUT_MONITOR -- requirements
Module: out_monitor

---
 rtl/out_monitor.sv | 160 ++++++++++++++++
 tb/tb_out_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/out_monitor.sv
// Measures a pulse train (high widths, low gaps, pulse count) against expected parameters
// and latches sticky pass/fail results until clear or reset.
module out_monitor #(
  parameter int HIGH_LEN = 6,
  parameter int LOW_LEN  = 1,
  parameter int PULSES   = 13,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          out_in,
  input  logic          running_in,
  input  logic          bis_end_in,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err_width,
  output logic          err_gap,
  output logic          err_count,
  output logic [CW-1:0] pulse_cnt,
  output logic [CW-1:0] last_high
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  localparam logic [CW-1:0] C_MAX    = '1;
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_HIGH   = CW'(HIGH_LEN);
  localparam logic [CW-1:0] C_LOW    = CW'(LOW_LEN);
  localparam logic [CW-1:0] C_PULSES = CW'(PULSES);

  state_t        r_state, w_state_nxt;
  logic          r_out_s, r_run_s, r_end_s;
  logic [CW-1:0] r_hcnt, r_lcnt, r_pcnt, r_last;
  logic [CW-1:0] w_hcnt_nxt, w_lcnt_nxt, w_pcnt_nxt, w_last_nxt;
  logic [CW-1:0] w_hcnt_inc, w_lcnt_inc, w_pcnt_inc;
  logic          r_errw, r_errg, r_errc;
  logic          w_errw_nxt, w_errg_nxt, w_errc_nxt;
  logic          r_busy, r_done, r_pass;

  assign w_hcnt_inc = (r_hcnt == C_MAX) ? C_MAX : r_hcnt + C_ONE;
  assign w_lcnt_inc = (r_lcnt == C_MAX) ? C_MAX : r_lcnt + C_ONE;
  assign w_pcnt_inc = (r_pcnt == C_MAX) ? C_MAX : r_pcnt + C_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_lcnt_nxt  = r_lcnt;
    w_pcnt_nxt  = r_pcnt;
    w_last_nxt  = r_last;
    w_errw_nxt  = r_errw;
    w_errg_nxt  = r_errg;
    w_errc_nxt  = r_errc;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_hcnt_nxt  = '0;
      w_lcnt_nxt  = '0;
      w_pcnt_nxt  = '0;
      w_last_nxt  = '0;
      w_errw_nxt  = 1'b0;
      w_errg_nxt  = 1'b0;
      w_errc_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_out_s && r_run_s) begin
            w_hcnt_nxt  = C_ONE;
            w_pcnt_nxt  = '0;
            w_last_nxt  = '0;
            w_state_nxt = S_HIGH;
          end
        end
        S_HIGH: begin
          if (r_end_s) begin
            // end-of-run while high still closes the open pulse
            w_last_nxt  = r_hcnt;
            w_pcnt_nxt  = w_pcnt_inc;
            w_errw_nxt  = r_errw | (r_hcnt != C_HIGH);
            w_errc_nxt  = r_errc | (w_pcnt_inc != C_PULSES);
            w_state_nxt = S_DONE;
          end else if (!r_run_s) begin
            w_errc_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else if (r_out_s) begin
            w_hcnt_nxt  = w_hcnt_inc;
          end else begin
            w_last_nxt  = r_hcnt;
            w_pcnt_nxt  = w_pcnt_inc;
            w_errw_nxt  = r_errw | (r_hcnt != C_HIGH);
            w_lcnt_nxt  = C_ONE;
            w_state_nxt = S_LOW;
          end
        end
        S_LOW: begin
          // the trailing low before end-of-run is never gap-checked
          if (r_end_s) begin
            w_errc_nxt  = r_errc | (r_pcnt != C_PULSES);
            w_state_nxt = S_DONE;
          end else if (!r_run_s) begin
            w_errc_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else if (r_out_s) begin
            w_errg_nxt  = r_errg | (r_lcnt != C_LOW);
            w_hcnt_nxt  = C_ONE;
            w_state_nxt = S_HIGH;
          end else begin
            w_lcnt_nxt  = w_lcnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_out_s <= 1'b0;
      r_run_s <= 1'b0;
      r_end_s <= 1'b0;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_pcnt  <= '0;
      r_last  <= '0;
      r_errw  <= 1'b0;
      r_errg  <= 1'b0;
      r_errc  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_out_s <= out_in;
      r_run_s <= running_in;
      r_end_s <= bis_end_in;
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_last  <= w_last_nxt;
      r_errw  <= w_errw_nxt;
      r_errg  <= w_errg_nxt;
      r_errc  <= w_errc_nxt;
      // status flags are decoded from the next state so they stay aligned with it
      r_busy  <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW);
      r_done  <= (w_state_nxt == S_DONE);
      r_pass  <= (w_state_nxt == S_DONE) && !(w_errw_nxt || w_errg_nxt || w_errc_nxt);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_width = r_errw;
  assign err_gap   = r_errg;
  assign err_count = r_errc;
  assign pulse_cnt = r_pcnt;
  assign last_high = r_last;

endmodule

// File: tb/tb_out_monitor.sv
// Self-checking bench for out_monitor: directed and randomized pulse trains compared
// against expectations computed from the pulse list.
module tb_out_monitor;
  localparam int HL = 6;
  localparam int LL = 1;
  localparam int NP = 13;
  localparam int CW = 4;
  localparam int MX = (1 << CW) - 1;

  localparam int M_END_LOW  = 0;
  localparam int M_END_HIGH = 1;
  localparam int M_ABORT    = 2;

  logic          clk = 1'b0;
  logic          reset, out_in, running_in, bis_end_in, clear;
  logic          busy, done, pass, err_width, err_gap, err_count;
  logic [CW-1:0] pulse_cnt, last_high;

  int n_vec = 0;
  int n_err = 0;
  int q_w[$];
  int q_g[$];

  out_monitor #(.HIGH_LEN(HL), .LOW_LEN(LL), .PULSES(NP), .CW(CW)) dut (
    .clk(clk), .reset(reset), .out_in(out_in), .running_in(running_in),
    .bis_end_in(bis_end_in), .clear(clear), .busy(busy), .done(done), .pass(pass),
    .err_width(err_width), .err_gap(err_gap), .err_count(err_count),
    .pulse_cnt(pulse_cnt), .last_high(last_high)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic o, input logic r, input logic e);
    @(negedge clk);
    out_in     = o;
    running_in = r;
    bis_end_in = e;
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".busy"},      32'(busy),      0);
    chk({name, ".done"},      32'(done),      0);
    chk({name, ".pass"},      32'(pass),      0);
    chk({name, ".err_width"}, 32'(err_width), 0);
    chk({name, ".err_gap"},   32'(err_gap),   0);
    chk({name, ".err_count"}, 32'(err_count), 0);
    chk({name, ".pulse_cnt"}, 32'(pulse_cnt), 0);
    chk({name, ".last_high"}, 32'(last_high), 0);
  endtask

  task automatic set_std(input int n);
    q_w.delete();
    q_g.delete();
    for (int i = 0; i < n; i++) begin
      q_w.push_back(HL);
      if (i < n - 1) q_g.push_back(LL);
    end
  endtask

  // Drives the pulse list in q_w/q_g, ends the run per mode, checks results, then clears.
  task automatic run_and_check(input string name, input int mode, input int ak, input int tail);
    int  n;
    int  e_cnt, e_last;
    bit  e_w, e_g, e_c;
    n = (mode == M_ABORT) ? ak : q_w.size();
    e_cnt  = (n > MX) ? MX : n;
    e_last = (q_w[n-1] > MX) ? MX : q_w[n-1];
    e_w = 0;
    e_g = 0;
    for (int i = 0; i < n; i++) if (q_w[i] != HL) e_w = 1;
    for (int i = 0; i < n - 1; i++) if (q_g[i] != LL) e_g = 1;
    e_c = (mode == M_ABORT) || (n != NP);

    cyc(0, 1, 0);
    for (int i = 0; i < n; i++) begin
      repeat (q_w[i]) cyc(1, 1, 0);
      if (i < n - 1) begin
        repeat (q_g[i]) cyc(0, 1, 0);
      end else if (mode == M_END_LOW) begin
        repeat (tail) cyc(0, 1, 0);
        cyc(0, 1, 1);
      end else if (mode == M_END_HIGH) begin
        cyc(1, 1, 1);
      end else begin
        cyc(0, 1, 0);
        cyc(0, 0, 0);
      end
      if (i == 0) begin
        @(posedge clk);
        #1;
        chk({name, ".busy_mid"}, 32'(busy), 1);
      end
    end
    repeat (3) cyc(0, 0, 0);
    // activity after completion must not disturb the held results
    repeat (3) cyc(1, 1, 0);
    cyc(0, 1, 1);
    repeat (3) cyc(0, 0, 0);
    @(negedge clk);
    chk({name, ".done"},      32'(done),      1);
    chk({name, ".busy"},      32'(busy),      0);
    chk({name, ".pass"},      32'(pass),      32'(!(e_w || e_g || e_c)));
    chk({name, ".err_width"}, 32'(err_width), 32'(e_w));
    chk({name, ".err_gap"},   32'(err_gap),   32'(e_g));
    chk({name, ".err_count"}, 32'(err_count), 32'(e_c));
    chk({name, ".pulse_cnt"}, 32'(pulse_cnt), 32'(e_cnt));
    chk({name, ".last_high"}, 32'(last_high), 32'(e_last));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_zero({name, ".clr"});
  endtask

  initial begin
    reset = 1'b1;
    out_in = 1'b0;
    running_in = 1'b0;
    bis_end_in = 1'b0;
    clear = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    set_std(NP);
    run_and_check("nominal", M_END_LOW, 0, 1);

    set_std(NP);
    q_w[3] = 7;
    run_and_check("wide_p4", M_END_LOW, 0, 1);

    set_std(NP);
    q_g[5] = 2;
    run_and_check("gap2", M_END_LOW, 0, 2);

    set_std(NP - 1);
    run_and_check("short12", M_END_LOW, 0, 1);

    set_std(NP);
    run_and_check("abort3", M_ABORT, 3, 1);

    set_std(NP);
    q_w[NP-1] = 4;
    run_and_check("end_high", M_END_HIGH, 0, 1);

    // reset in the middle of a run
    cyc(0, 1, 0);
    repeat (HL) cyc(1, 1, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(1, 1, 0);
    #2;
    reset = 1'b1;
    out_in = 1'b0;
    running_in = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(0, 0, 0);
    @(negedge clk);
    chk_zero("post_reset");
    set_std(NP);
    run_and_check("after_reset", M_END_LOW, 0, 1);

    for (int r = 0; r < 30; r++) begin
      int n, sel, mode, ak;
      sel = $urandom_range(0, 7);
      n = (sel == 0) ? NP - 1 : (sel == 1) ? NP + 1 : NP;
      q_w.delete();
      q_g.delete();
      for (int i = 0; i < n; i++) begin
        q_w.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : HL);
        if (i < n - 1) q_g.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : LL);
      end
      sel = $urandom_range(0, 5);
      mode = (sel == 0) ? M_END_HIGH : (sel == 1) ? M_ABORT : M_END_LOW;
      ak = $urandom_range(1, n);
      run_and_check($sformatf("rnd%0d", r), mode, ak, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
